signed_divider_32bit: RTL and testbench

Multi-cycle 32-bit signed integer divider that produces quotient and remainder using a restoring shift-subtract algorithm, one quotient bit per clock. It is the inverse operation to the signed Vedic multiplier and sits beside it in the arithmetic datapath behind a start/busy/done handshake. The trial subtraction is performed by one instance of the team's `CLA_32bit` adder, driven with the inverted divisor and carry-in 1.

---
 rtl/signed_divider_32bit_if.sv | 43 ++++
 rtl/signed_divider_32bit.sv | 197 +++++++++++++++++++
 tb/tb_signed_divider_32bit.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/signed_divider_32bit_if.sv
// -----------------------------------------------------------------------------
// signed_divider_32bit_if
//
// Groups the request/result signals of the 32-bit signed divider.
//
// Handshake: the requester raises `start` for one or more cycles with the
// operands on `dividend`/`divisor`. The divider samples `start` only while it
// is idle, and it captures the operands on that edge. `busy` is high from the
// next cycle until the result is written. `done` then pulses high for exactly
// one cycle, with `quotient`/`remainder`/`div_by_zero` valid. The divider
// ignores `start` while `busy` is high. It accepts `start` during the `done`
// cycle. There is no back-pressure on results.
//
// Signals:
//   start        requester -> divider  request strobe
//   dividend     requester -> divider  signed 32-bit numerator
//   divisor      requester -> divider  signed 32-bit denominator
//   quotient     divider -> requester  signed quotient, truncated toward zero
//   remainder    divider -> requester  signed remainder, sign of dividend
//   busy         divider -> requester  operation in progress
//   done         divider -> requester  one-cycle result-valid pulse
//   div_by_zero  divider -> requester  last accepted divisor was zero
// -----------------------------------------------------------------------------
interface signed_divider_32bit_if;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero
  );
endinterface

// File: rtl/signed_divider_32bit.sv
// -----------------------------------------------------------------------------
// signed_divider_32bit
//
// Multi-cycle 32-bit signed divider. It uses a restoring shift-subtract
// algorithm and produces one quotient bit per clock. The divider works on the
// operand magnitudes, then fixes the result signs in a final cycle.
// Quotient truncates toward zero, and the remainder takes the sign of the
// dividend. Division by zero returns quotient 0xFFFFFFFF and remainder =
// dividend, and it raises div_by_zero.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   bus        signed_divider_32bit_if.slave (start/operands/results/handshake)
//   state_dbg  current FSM state (0 IDLE, 1 CALC, 2 FIX)
//
// Timing: a start accepted at edge k gives busy after edge k. CALC runs on
// edges k+1..k+32. FIX writes the results and raises done at edge k+33.
// A zero divisor skips CALC, so done rises at edge k+1.
// -----------------------------------------------------------------------------
module signed_divider_32bit (
  input  logic                        clk,
  input  logic                        rst,
  signed_divider_32bit_if.slave       bus,
  output logic [1:0]                  state_dbg
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  logic [1:0]  state;
  logic [31:0] q_reg;      // dividend magnitude shifting out / quotient bits shifting in
  logic [31:0] r_reg;      // partial remainder (raw dividend on the div-by-zero path)
  logic [31:0] d_reg;      // divisor magnitude
  logic [4:0]  count;
  logic        neg_q;
  logic        neg_r;
  logic        dz_pending;

  logic [31:0] abs_dividend;
  logic [31:0] abs_divisor;
  logic [31:0] s_val;
  logic [31:0] t_val;
  logic        shift_out;
  logic        carry;
  logic        take_sub;

  // Magnitudes are unsigned 32-bit, so |0x80000000| stays 0x80000000.
  assign abs_dividend = bus.dividend[31] ? (~bus.dividend + 32'd1) : bus.dividend;
  assign abs_divisor  = bus.divisor[31]  ? (~bus.divisor  + 32'd1) : bus.divisor;

  // Shift the next dividend bit into the partial remainder. The bit that
  // falls off the top (shift_out) is the 33rd bit of the true shifted value.
  assign s_val     = {r_reg[30:0], q_reg[31]};
  assign shift_out = r_reg[31];

  // Trial subtraction S - D as S + ~D + 1. A carry-out means no borrow.
  CLA_32bit u_sub (
    .a    (s_val),
    .b    (~d_reg),
    .cin  (1'b1),
    .sum  (t_val),
    .cout (carry)
  );

  // If the shifted-out bit is set, the 33-bit partial remainder is >= 2^32,
  // which always exceeds D. The 32-bit difference is then the exact result.
  assign take_sub = carry | shift_out;

  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      q_reg           <= 32'd0;
      r_reg           <= 32'd0;
      d_reg           <= 32'd0;
      count           <= 5'd0;
      neg_q           <= 1'b0;
      neg_r           <= 1'b0;
      dz_pending      <= 1'b0;
      bus.quotient    <= 32'd0;
      bus.remainder   <= 32'd0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.div_by_zero <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            bus.busy        <= 1'b1;
            bus.div_by_zero <= 1'b0;
            neg_q           <= bus.dividend[31] ^ bus.divisor[31];
            neg_r           <= bus.dividend[31];
            count           <= 5'd0;
            if (bus.divisor == 32'd0) begin
              // r_reg carries the raw dividend through to FIX.
              dz_pending <= 1'b1;
              q_reg      <= 32'd0;
              r_reg      <= bus.dividend;
              d_reg      <= 32'd0;
              state      <= ST_FIX;
            end else begin
              dz_pending <= 1'b0;
              q_reg      <= abs_dividend;
              r_reg      <= 32'd0;
              d_reg      <= abs_divisor;
              state      <= ST_CALC;
            end
          end
        end

        ST_CALC: begin
          if (take_sub) begin
            r_reg <= t_val;
            q_reg <= {q_reg[30:0], 1'b1};
          end else begin
            r_reg <= s_val;
            q_reg <= {q_reg[30:0], 1'b0};
          end
          count <= count + 5'd1;
          if (count == 5'd31) begin
            state <= ST_FIX;
          end
        end

        ST_FIX: begin
          if (dz_pending) begin
            bus.quotient    <= 32'hFFFF_FFFF;
            bus.remainder   <= r_reg;
            bus.div_by_zero <= 1'b1;
          end else begin
            // -2^31 / -1 wraps here to 0x80000000 with no flag.
            bus.quotient  <= neg_q ? (~q_reg + 32'd1) : q_reg;
            bus.remainder <= neg_r ? (~r_reg + 32'd1) : r_reg;
          end
          dz_pending <= 1'b0;
          bus.done   <= 1'b1;
          bus.busy   <= 1'b0;
          state      <= ST_IDLE;
        end

        default: begin
          state    <= ST_IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// -----------------------------------------------------------------------------
// CLA_32bit
//
// 32-bit carry-lookahead adder. It is built from eight 4-bit lookahead groups
// whose group carries ripple from one group to the next.
//
// Ports:
//   a, b   32-bit addends
//   cin    carry in
//   sum    32-bit sum
//   cout   carry out of bit 31
// -----------------------------------------------------------------------------
module CLA_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [31:0] g;
  logic [31:0] p;
  logic [32:0] c;

  assign g    = a & b;
  assign p    = a ^ b;
  assign c[0] = cin;

  for (genvar k = 0; k < 8; k++) begin : g_grp
    localparam int B = 4 * k;
    assign c[B+1] = g[B] | (p[B] & c[B]);
    assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & c[B]);
    assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                  | (p[B+2] & p[B+1] & p[B] & c[B]);
    assign c[B+4] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                  | (p[B+3] & p[B+2] & p[B+1] & g[B])
                  | (p[B+3] & p[B+2] & p[B+1] & p[B] & c[B]);
  end

  assign sum  = p ^ c[31:0];
  assign cout = c[32];

endmodule

// File: tb/tb_signed_divider_32bit.sv
// -----------------------------------------------------------------------------
// tb_signed_divider_32bit
//
// Self-checking bench for signed_divider_32bit. Each request pushes
// {div_by_zero, quotient, remainder} into exp_q. The expected values come from
// a magnitude-based reference. Entries are popped and compared when done rises.
// -----------------------------------------------------------------------------
module tb_signed_divider_32bit;

  logic       clk;
  logic       rst;
  logic [1:0] state_dbg;

  signed_divider_32bit_if bus ();

  signed_divider_32bit dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [64:0] exp_q[$];

  // busy and done must never be high together.
  always @(negedge clk) begin
    if (!rst && bus.busy === 1'b1 && bus.done === 1'b1) begin
      n_fail++;
      $display("FAIL busy_done_overlap: busy=%b done=%b required not both 1", bus.busy, bus.done);
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [64:0] model(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ua, ub, uq, ur, q, r;
    if (b == 32'd0) return {1'b1, 32'hFFFF_FFFF, a};
    ua = a[31] ? (32'd0 - a) : a;
    ub = b[31] ? (32'd0 - b) : b;
    uq = ua / ub;
    ur = ua % ub;
    q  = (a[31] ^ b[31]) ? (32'd0 - uq) : uq;
    r  = a[31] ? (32'd0 - ur) : ur;
    return {1'b0, q, r};
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a negedge: raises start for one clock, and records the
  // expectation when the request is meant to be accepted.
  task automatic drive_start(input logic [31:0] a, input logic [31:0] b, input bit push);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    if (push) exp_q.push_back(model(a, b));
    @(negedge clk);
    bus.start    = 1'b0;
    bus.dividend = $urandom;
    bus.divisor  = $urandom;
  endtask

  // Waits at negedges for done. cyc counts clocks since the start edge.
  task automatic wait_done(input int cyc_in, output int cyc, output bit got);
    cyc = cyc_in;
    while (bus.done !== 1'b1 && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    got = (bus.done === 1'b1);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.dividend = 32'd0;
    bus.divisor  = 32'd0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder, state_dbg} !== 69'd0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b dz=%b q=%h r=%h st=%0d required all 0",
               bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder, state_dbg);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int cyc; bit got; logic [64:0] e;
    drive_start(32'd100, 32'd7, 1'b1);
    n_checks++;
    if (bus.busy !== 1'b1 || state_dbg !== 2'd1) begin
      n_fail++;
      $display("FAIL basic_busy: busy=%b st=%0d required busy=1 st=1", bus.busy, state_dbg);
    end
    wait_done(1, cyc, got);
    e = exp_q.pop_front();
    n_checks++;
    if (!got || cyc != 34) begin
      n_fail++;
      $display("FAIL basic_latency: got=%b cycles=%0d required 34", got, cyc);
    end
    n_checks++;
    if ({bus.div_by_zero, bus.quotient, bus.remainder} !== e) begin
      n_fail++;
      $display("FAIL basic_result: dz=%b q=%h r=%h required dz=%b q=%h r=%h",
               bus.div_by_zero, bus.quotient, bus.remainder, e[64], e[63:32], e[31:0]);
    end
    @(negedge clk);
    n_checks++;
    if (bus.done !== 1'b0 || bus.quotient !== e[63:32]) begin
      n_fail++;
      $display("FAIL basic_pulse_hold: done=%b q=%h required done=0 q=%h", bus.done, bus.quotient, e[63:32]);
    end
  endtask

  task automatic test_signs();
    logic [31:0] ta[6] = '{32'hFFFF_FF9C, 32'd100, 32'hFFFF_FF9C, 32'h8000_0000, 32'h7FFF_FFFF, 32'd5};
    logic [31:0] tb[6] = '{32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'd1, 32'd9};
    int cyc; bit got; logic [64:0] e;
    logic [31:0] a, b;
    for (int i = 0; i < 12; i++) begin
      if (i < 6) begin
        a = ta[i];
        b = tb[i];
      end else begin
        a = $urandom;
        b = $urandom >> $urandom_range(0, 31);
        if (b == 32'd0) b = 32'd3;
      end
      drive_start(a, b, 1'b1);
      wait_done(1, cyc, got);
      e = exp_q.pop_front();
      n_checks++;
      if (!got || cyc != 34 || {bus.div_by_zero, bus.quotient, bus.remainder} !== e) begin
        n_fail++;
        $display("FAIL signs_%0d: a=%h b=%h got=%b cyc=%0d dz=%b q=%h r=%h required cyc=34 dz=%b q=%h r=%h",
                 i, a, b, got, cyc, bus.div_by_zero, bus.quotient, bus.remainder, e[64], e[63:32], e[31:0]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_div_zero();
    int cyc; bit got; logic [64:0] e;
    drive_start(32'd1234, 32'd0, 1'b1);
    n_checks++;
    if (bus.busy !== 1'b1 || state_dbg !== 2'd2) begin
      n_fail++;
      $display("FAIL dz_path: busy=%b st=%0d required busy=1 st=2", bus.busy, state_dbg);
    end
    wait_done(1, cyc, got);
    e = exp_q.pop_front();
    n_checks++;
    if (!got || cyc != 2 || {bus.div_by_zero, bus.quotient, bus.remainder} !== e) begin
      n_fail++;
      $display("FAIL dz_result: got=%b cyc=%0d dz=%b q=%h r=%h required cyc=2 dz=%b q=%h r=%h",
               got, cyc, bus.div_by_zero, bus.quotient, bus.remainder, e[64], e[63:32], e[31:0]);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.div_by_zero !== 1'b1) begin
      n_fail++;
      $display("FAIL dz_hold: dz=%b required 1", bus.div_by_zero);
    end
    drive_start(32'd10, 32'd3, 1'b1);
    n_checks++;
    if (bus.div_by_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL dz_clear: dz=%b required 0", bus.div_by_zero);
    end
    wait_done(1, cyc, got);
    e = exp_q.pop_front();
    n_checks++;
    if (!got || cyc != 34 || {bus.div_by_zero, bus.quotient, bus.remainder} !== e) begin
      n_fail++;
      $display("FAIL dz_followup: got=%b cyc=%0d dz=%b q=%h r=%h required cyc=34 dz=%b q=%h r=%h",
               got, cyc, bus.div_by_zero, bus.quotient, bus.remainder, e[64], e[63:32], e[31:0]);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int cyc; bit got; logic [64:0] e;
    drive_start(32'd50, 32'd5, 1'b1);
    repeat (8) @(negedge clk);
    drive_start(32'd9, 32'd3, 1'b0);   // arrives while busy: must be ignored
    wait_done(10, cyc, got);
    e = exp_q.pop_front();
    n_checks++;
    if (!got || cyc != 34 || {bus.div_by_zero, bus.quotient, bus.remainder} !== e) begin
      n_fail++;
      $display("FAIL ignore_start: got=%b cyc=%0d dz=%b q=%h r=%h required cyc=34 dz=%b q=%h r=%h",
               got, cyc, bus.div_by_zero, bus.quotient, bus.remainder, e[64], e[63:32], e[31:0]);
    end
    // Start during the done cycle is accepted.
    drive_start(32'd9, 32'd3, 1'b1);
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_accept: busy=%b required 1", bus.busy);
    end
    wait_done(1, cyc, got);
    e = exp_q.pop_front();
    n_checks++;
    if (!got || cyc != 34 || {bus.div_by_zero, bus.quotient, bus.remainder} !== e) begin
      n_fail++;
      $display("FAIL b2b_result: got=%b cyc=%0d dz=%b q=%h r=%h required cyc=34 dz=%b q=%h r=%h",
               got, cyc, bus.div_by_zero, bus.quotient, bus.remainder, e[64], e[63:32], e[31:0]);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int cyc; bit got; bit seen; logic [64:0] e;
    drive_start(32'd77, 32'd4, 1'b0);  // will be aborted, so no expectation
    repeat (13) @(negedge clk);        // now 14 clocks after the start edge
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder, state_dbg} !== 69'd0) begin
      n_fail++;
      $display("FAIL mid_reset: busy=%b done=%b dz=%b q=%h r=%h st=%0d required all 0",
               bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder, state_dbg);
    end
    rst  = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL mid_reset_no_done: done seen=1 required 0");
    end
    drive_start(32'd100, 32'd7, 1'b1);
    wait_done(1, cyc, got);
    e = exp_q.pop_front();
    n_checks++;
    if (!got || cyc != 34 || {bus.div_by_zero, bus.quotient, bus.remainder} !== e) begin
      n_fail++;
      $display("FAIL mid_reset_recover: got=%b cyc=%0d dz=%b q=%h r=%h required cyc=34 dz=%b q=%h r=%h",
               got, cyc, bus.div_by_zero, bus.quotient, bus.remainder, e[64], e[63:32], e[31:0]);
    end
    @(negedge clk);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_div_zero();
    test_back_to_back();
    test_reset_mid();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: pending=%0d required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
